// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_W   : width of an ID-stage source register index
//   WREG_W  : width of the EX-stage destination field (top code = no write)
//   NO_REG  : destination code meaning "instruction writes no register"
//   state_t : controller states
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W  = 4;
  localparam int WREG_W = 5;
  localparam logic [WREG_W-1:0] NO_REG = 5'b11111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle.
//   ID/EX/MEM status : id_readReg0/1, id_use0/1, ex_ReadMem, ex_writeReg,
//                      ex_redirect, mem_busy        (pipeline -> controller)
//   Pipeline control : hazard_detected, pc_write, if_flush, pipe_hold
//   Perf counters    : cycle_count, stall_count, flush_count (CNT_W bits)
// master = pipeline side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_W-1:0]  id_readReg0;
  logic [REG_W-1:0]  id_readReg1;
  logic              id_use0;
  logic              id_use1;
  logic              ex_ReadMem;
  logic [WREG_W-1:0] ex_writeReg;
  logic              ex_redirect;
  logic              mem_busy;

  logic              hazard_detected;
  logic              pc_write;
  logic              if_flush;
  logic              pipe_hold;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_readReg0, id_readReg1, id_use0, id_use1,
           ex_ReadMem, ex_writeReg, ex_redirect, mem_busy,
    input  hazard_detected, pc_write, if_flush, pipe_hold,
           cycle_count, stall_count, flush_count
  );

  modport slave (
    input  id_readReg0, id_readReg1, id_use0, id_use1,
           ex_ReadMem, ex_writeReg, ex_redirect, mem_busy,
    output hazard_detected, pc_write, if_flush, pipe_hold,
           cycle_count, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_cnt.sv
// Saturating up-counter used for the performance counters.
//   clk, rst : clock, async active-high reset (clears count)
//   en_i     : count this cycle
//   count_o  : current value; holds at all-ones
module hazard_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flush and
// memory-busy freeze, plus cycle/stall/flush performance counters.
//   clk, rst : clock, async active-high reset
//   hz       : slave side of pipeline_hazard_ctrl_if (status in, control
//              and counters out)
// Control outputs are combinational from state and the current inputs so
// that a load-use or memory stall takes effect in the cycle it is seen.
//
// state    | meaning
// RUN      | normal issue; load-use bubbles inserted in place
// MEM_WAIT | data memory busy, whole pipeline frozen
// FLUSH    | discarding wrong-path fetches after a redirect
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   hz
);

  // Remaining FLUSH-state cycles after the redirect cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;

  logic lu;
  logic redirect_acc;
  logic pc_write_d, hazard_d, if_flush_d, pipe_hold_d;

  // Only the low REG_W bits name a register; NO_REG is excluded first.
  assign lu = hz.ex_ReadMem && (hz.ex_writeReg != NO_REG) &&
              ((hz.id_use0 && (hz.ex_writeReg[REG_W-1:0] == hz.id_readReg0)) ||
               (hz.id_use1 && (hz.ex_writeReg[REG_W-1:0] == hz.id_readReg1)));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_write_d   = 1'b1;
    hazard_d     = 1'b0;
    if_flush_d   = 1'b0;
    pipe_hold_d  = 1'b0;
    redirect_acc = 1'b0;

    if (rst) begin
      // Keep the IF/ID latch at a bubble and the PC still during reset.
      pc_write_d = 1'b0;
      hazard_d   = 1'b1;
    end else begin
      case (state_q)
        // MEM_WAIT with mem_busy low releases in the same cycle, so it
        // behaves exactly like RUN; otherwise a freeze would last one
        // cycle longer than the memory stall.
        RUN, MEM_WAIT: begin
          if (hz.mem_busy) begin
            pipe_hold_d = 1'b1;
            pc_write_d  = 1'b0;
            state_d     = MEM_WAIT;
          end else if (hz.ex_redirect) begin
            if_flush_d   = 1'b1;
            hazard_d     = 1'b1;
            redirect_acc = 1'b1;
            fcnt_d       = FLUSH_RELOAD;
            state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else begin
            state_d = RUN;
            if (lu) begin
              hazard_d   = 1'b1;
              pc_write_d = 1'b0;
            end
          end
        end
        FLUSH: begin
          if (hz.mem_busy) begin
            pipe_hold_d = 1'b1;
            pc_write_d  = 1'b0;
          end else begin
            if_flush_d = 1'b1;
            hazard_d   = 1'b1;
            if (hz.ex_redirect) begin
              redirect_acc = 1'b1;
              fcnt_d       = FLUSH_RELOAD;
            end else if (fcnt_q <= 3'd1) begin
              fcnt_d  = '0;
              state_d = RUN;
            end else begin
              fcnt_d = fcnt_q - 3'd1;
            end
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign hz.pc_write        = pc_write_d;
  assign hz.hazard_detected = hazard_d;
  assign hz.if_flush        = if_flush_d;
  assign hz.pipe_hold       = pipe_hold_d;

  hazard_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .count_o (hz.cycle_count)
  );

  hazard_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (!pc_write_d),
    .count_o (hz.stall_count)
  );

  hazard_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (redirect_acc),
    .count_o (hz.flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (A: FLUSH_CYCLES=2, 32-bit
// counters; B: FLUSH_CYCLES=4, 4-bit counters) driven with identical stimulus
// and compared every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if_b ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_a (
    .clk (clk), .rst (rst), .hz (if_a.slave)
  );
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(4)) u_b (
    .clk (clk), .rst (rst), .hz (if_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus for the next cycle.
  bit       s_rst;
  bit [3:0] s_r0, s_r1;
  bit       s_u0, s_u1, s_rm, s_redir, s_busy;
  bit [4:0] s_wr;

  // Model state: remaining flush cycles and counter values per instance.
  int     m_fc [2] = '{2, 4};
  longint m_max[2] = '{64'hFFFF_FFFF, 15};
  int     m_rem[2];
  longint m_cyc[2], m_stl[2], m_fls[2];

  function automatic longint inc_sat(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic set_idle();
    s_rst = 0; s_r0 = 0; s_r1 = 0; s_u0 = 0; s_u1 = 0;
    s_rm = 0; s_wr = 5'd31; s_redir = 0; s_busy = 0;
  endtask

  task automatic run_cycle();
    bit lu, acc;
    bit e_pc, e_hz, e_fl, e_hd;
    longint o_pc, o_hz, o_fl, o_hd, o_cyc, o_stl, o_fls;
    string p;
    @(negedge clk);
    rst = s_rst;
    if_a.id_readReg0 = s_r0;  if_b.id_readReg0 = s_r0;
    if_a.id_readReg1 = s_r1;  if_b.id_readReg1 = s_r1;
    if_a.id_use0 = s_u0;      if_b.id_use0 = s_u0;
    if_a.id_use1 = s_u1;      if_b.id_use1 = s_u1;
    if_a.ex_ReadMem = s_rm;   if_b.ex_ReadMem = s_rm;
    if_a.ex_writeReg = s_wr;  if_b.ex_writeReg = s_wr;
    if_a.ex_redirect = s_redir; if_b.ex_redirect = s_redir;
    if_a.mem_busy = s_busy;   if_b.mem_busy = s_busy;
    #1;
    lu = s_rm && (s_wr != 5'd31) &&
         ((s_u0 && (s_wr[3:0] == s_r0)) || (s_u1 && (s_wr[3:0] == s_r1)));
    for (int k = 0; k < 2; k++) begin
      acc = 0;
      e_pc = 1; e_hz = 0; e_fl = 0; e_hd = 0;
      if (s_rst) begin
        e_pc = 0; e_hz = 1;
        m_rem[k] = 0; m_cyc[k] = 0; m_stl[k] = 0; m_fls[k] = 0;
      end else if (s_busy) begin
        e_hd = 1; e_pc = 0;
      end else if (s_redir) begin
        e_fl = 1; e_hz = 1; acc = 1;
        m_rem[k] = m_fc[k] - 1;
      end else if (m_rem[k] > 0) begin
        e_fl = 1; e_hz = 1;
        m_rem[k]--;
      end else if (lu) begin
        e_hz = 1; e_pc = 0;
      end
      if (k == 0) begin
        p = "a";
        o_pc = if_a.pc_write; o_hz = if_a.hazard_detected;
        o_fl = if_a.if_flush; o_hd = if_a.pipe_hold;
        o_cyc = if_a.cycle_count; o_stl = if_a.stall_count; o_fls = if_a.flush_count;
      end else begin
        p = "b";
        o_pc = if_b.pc_write; o_hz = if_b.hazard_detected;
        o_fl = if_b.if_flush; o_hd = if_b.pipe_hold;
        o_cyc = if_b.cycle_count; o_stl = if_b.stall_count; o_fls = if_b.flush_count;
      end
      check_eq({p, ".pc_write"}, o_pc, e_pc);
      check_eq({p, ".hazard_detected"}, o_hz, e_hz);
      check_eq({p, ".if_flush"}, o_fl, e_fl);
      check_eq({p, ".pipe_hold"}, o_hd, e_hd);
      check_eq({p, ".cycle_count"}, o_cyc, m_cyc[k]);
      check_eq({p, ".stall_count"}, o_stl, m_stl[k]);
      check_eq({p, ".flush_count"}, o_fls, m_fls[k]);
      if (!s_rst) begin
        m_cyc[k] = inc_sat(m_cyc[k], m_max[k]);
        if (!e_pc) m_stl[k] = inc_sat(m_stl[k], m_max[k]);
        if (acc)   m_fls[k] = inc_sat(m_fls[k], m_max[k]);
      end
    end
  endtask

  task automatic do_reset(input int n);
    set_idle();
    s_rst = 1;
    repeat (n) run_cycle();
    s_rst = 0;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) run_cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    do_reset(2);

    // Load-use on readReg1: one bubble, then normal issue.
    s_rm = 1; s_wr = 5'd3; s_r1 = 4'd3; s_u1 = 1;
    run_cycle();
    idle_cycles(1);
    check_eq("req021.stall_count", if_a.stall_count, 1);

    // Same pattern with no destination register: no hazard.
    s_rm = 1; s_wr = 5'd31; s_r1 = 4'd15; s_u1 = 1;
    run_cycle();
    idle_cycles(1);
    check_eq("req022.stall_count", if_a.stall_count, 1);

    // Redirect pulse: two flush cycles on A, flush_count 1.
    do_reset(1);
    s_redir = 1;
    run_cycle();
    idle_cycles(4);
    check_eq("req023.flush_count", if_a.flush_count, 1);
    check_eq("req023.if_flush_after", if_a.if_flush, 0);

    // Redirect + load-use while memory busy: freeze, then redirect retried.
    do_reset(1);
    repeat (3) begin
      set_idle();
      s_busy = 1; s_redir = 1; s_rm = 1; s_wr = 5'd5; s_r0 = 4'd5; s_u0 = 1;
      run_cycle();
    end
    check_eq("req024.flush_count_frozen", if_a.flush_count, 0);
    set_idle();
    s_redir = 1;
    run_cycle();
    idle_cycles(1);
    check_eq("req024.flush_count_retry", if_a.flush_count, 1);

    // Reset in the middle of a four-cycle flush on B.
    do_reset(1);
    s_redir = 1;
    run_cycle();
    idle_cycles(1);
    do_reset(2);
    check_eq("req025.if_flush_in_rst", if_b.if_flush, 0);
    check_eq("req025.flush_count_in_rst", if_b.flush_count, 0);
    check_eq("req025.cycle_count_in_rst", if_b.cycle_count, 0);
    idle_cycles(1);
    check_eq("req025.pc_write_after", if_b.pc_write, 1);

    // Saturation of B's 4-bit counters under a long memory stall.
    do_reset(1);
    set_idle();
    s_busy = 1;
    repeat (20) run_cycle();
    idle_cycles(1);
    check_eq("req026.stall_count", if_b.stall_count, 15);
    check_eq("req026.cycle_count", if_b.cycle_count, 15);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      s_rst   = ($urandom_range(0, 99) == 0);
      s_r0    = 4'($urandom_range(0, 15));
      s_r1    = 4'($urandom_range(0, 15));
      s_u0    = 1'($urandom_range(0, 1));
      s_u1    = 1'($urandom_range(0, 1));
      s_rm    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       s_wr = 5'd31;
        1:       s_wr = {1'($urandom_range(0, 1)), s_r0};
        2:       s_wr = {1'($urandom_range(0, 1)), s_r1};
        default: s_wr = 5'($urandom_range(0, 31));
      endcase
      s_busy  = ($urandom_range(0, 4) == 0);
      s_redir = ($urandom_range(0, 5) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: `clk` is the single clock, and `rst` is an asynchronous, active-high reset.
REQ-002 Parameter FLUSH_CYCLES, default 1 (legal 1..7), SHALL set the number of bubble cycles inserted after a taken branch or jump.
REQ-003 Parameter CNT_W, default 32, SHALL set the width of every performance counter.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- id_readReg0  in  4  source register 0 of the instruction in ID.
- id_readReg1  in  4  source register 1 of the instruction in ID.
- id_use0  in  1  ID instruction reads readReg0.
- id_use1  in  1  ID instruction reads readReg1.
- ex_ReadMem  in  1  instruction in EX is a load.
- ex_writeReg  in  5  destination of EX instruction; 5'b11111 = no write.
- ex_redirect  in  1  taken branch or jump resolved in EX (single-cycle pulse).
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- hazard_detected  out  1  to IF/ID latch; replaces latch contents with a bubble.
- pc_write  out  1  PC update enable.
- if_flush  out  1  discard the instruction being fetched.
- pipe_hold  out  1  freeze all pipeline latches (no update, no bubble).
- cycle_count  out  CNT_W  cycles since reset.
- stall_count  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  redirects accepted.

Function
REQ-005 The FSM SHALL have three states: RUN, MEM_WAIT and FLUSH.
REQ-006 Load-use hazard (LU) SHALL be asserted when ex_ReadMem=1, ex_writeReg!=5'b11111, and either (id_use0 and ex_writeReg[3:0]==id_readReg0) or (id_use1 and ex_writeReg[3:0]==id_readReg1).
REQ-007 In RUN, next-state priority SHALL be: mem_busy→MEM_WAIT, else ex_redirect→FLUSH (load FLUSH_CYCLES-1 into the flush counter), else RUN.
REQ-008 In RUN with mem_busy=0, ex_redirect=0 and LU=1, outputs SHALL be combinational in the same cycle: hazard_detected=1, pc_write=0; the state SHALL remain RUN, giving exactly one bubble per load-use.
REQ-009 In RUN, mem_busy=1 SHALL force pipe_hold=1, pc_write=0, hazard_detected=0 and if_flush=0 in that cycle, regardless of LU or ex_redirect.
REQ-010 In MEM_WAIT, outputs SHALL be pipe_hold=1, pc_write=0 and all others 0; the state SHALL return to RUN on the first cycle mem_busy=0, and ex_redirect is ignored while mem_busy=1.
REQ-011 In RUN, an ex_redirect=1 cycle with mem_busy=0 SHALL drive if_flush=1, hazard_detected=1 and pc_write=1 (the PC loads the target), and LU SHALL be ignored in that cycle.
REQ-012 In FLUSH, outputs SHALL be if_flush=1, hazard_detected=1 and pc_write=1; the counter SHALL decrement each cycle, with FLUSH→RUN when the counter is 0. With FLUSH_CYCLES=1, FLUSH SHALL NOT be entered.
REQ-013 In FLUSH, mem_busy=1 SHALL take priority: pipe_hold=1, pc_write=0, the flush counter frozen, and the state held in FLUSH.
REQ-014 A new ex_redirect during FLUSH SHALL reload the counter and increment flush_count.
REQ-015 cycle_count SHALL increment every cycle; stall_count SHALL increment each cycle with pc_write=0; flush_count SHALL increment each accepted ex_redirect. All counters SHALL saturate at all-ones.
REQ-016 When no condition of REQ-008 to REQ-013 applies, outputs SHALL be pc_write=1 and all others 0.

Reset
REQ-017 While rst=1: state=RUN, flush counter=0, all counters=0, pc_write=0, hazard_detected=1, if_flush=0, pipe_hold=0; the IF/ID latch is thereby held at a bubble.
REQ-018 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abort immediately, and the first cycle after release SHALL be RUN with pc_write=1.

Structure
REQ-019 A shared package SHALL hold: the state enum, the NO_REG constant (5'b11111) and the REG_W (4) and WREG_W (5) widths.
REQ-020 One sub-module, hazard_cnt (saturating counter: enable, width parameter), SHALL be instantiated three times; the FSM and LU logic SHALL be top-level.

Verification
REQ-021 Load-use: ex_ReadMem=1, ex_writeReg=5'd3, id_readReg1=3, id_use1=1 → same cycle hazard_detected=1, pc_write=0; next cycle (ex_ReadMem=0) pc_write=1; stall_count=1.
REQ-022 No-write: same as REQ-021 but ex_writeReg=5'b11111 → hazard_detected=0, pc_write=1.
REQ-023 Redirect: FLUSH_CYCLES=2, ex_redirect pulse → if_flush=1 for 2 cycles, then 0; flush_count=1.
REQ-024 Simultaneous: ex_redirect=1, LU=1, mem_busy=1 for 3 cycles → pipe_hold=1 for 3 cycles, no flush; redirect re-presented after the stall is then accepted.
REQ-025 Reset mid-FLUSH (FLUSH_CYCLES=4, rst at cycle 2) → all counters 0, if_flush=0, and the first cycle after release has pc_write=1.
REQ-026 Saturation: CNT_W=4, 20 cycles of mem_busy=1 → stall_count=15 and cycle_count=15.
